// File: rtl/hit_resolver.sv
// Per-frame hit resolution for a two-player fighter: hitbox/hurtbox overlap,
// one-frame hit pulses, health/block bookkeeping with block regen, round end and winner.
module hit_resolver #(
  parameter logic [2:0] HEALTH_MAX  = 3'd5,
  parameter logic [2:0] BLOCK_MAX   = 3'd3,
  parameter int         BLOCK_REGEN = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] gamestate,
  input  logic [3:0] p1_state,
  input  logic [3:0] p2_state,
  input  logic [9:0] p1_basic_x1,
  input  logic [9:0] p1_basic_x2,
  input  logic [9:0] p1_basic_y1,
  input  logic [9:0] p1_basic_y2,
  input  logic [9:0] p1_dir_x1,
  input  logic [9:0] p1_dir_x2,
  input  logic [9:0] p1_dir_y1,
  input  logic [9:0] p1_dir_y2,
  input  logic [9:0] p1_hurt_x1,
  input  logic [9:0] p1_hurt_x2,
  input  logic [9:0] p1_hurt_y1,
  input  logic [9:0] p1_hurt_y2,
  input  logic [9:0] p2_basic_x1,
  input  logic [9:0] p2_basic_x2,
  input  logic [9:0] p2_basic_y1,
  input  logic [9:0] p2_basic_y2,
  input  logic [9:0] p2_dir_x1,
  input  logic [9:0] p2_dir_x2,
  input  logic [9:0] p2_dir_y1,
  input  logic [9:0] p2_dir_y2,
  input  logic [9:0] p2_hurt_x1,
  input  logic [9:0] p2_hurt_x2,
  input  logic [9:0] p2_hurt_y1,
  input  logic [9:0] p2_hurt_y2,
  output logic [1:0] p1_hitFlag,
  output logic [1:0] p2_hitFlag,
  output logic [2:0] p1_health,
  output logic [2:0] p2_health,
  output logic [2:0] p1_block,
  output logic [2:0] p2_block,
  output logic       round_over,
  output logic [1:0] winner
);

  localparam int             CW         = $clog2(BLOCK_REGEN);
  localparam logic [CW-1:0]  REGEN_LAST = CW'(BLOCK_REGEN - 1);
  localparam logic [3:0]     ST_BACK      = 4'd2;
  localparam logic [3:0]     ST_BATK      = 4'd4;
  localparam logic [3:0]     ST_DATK      = 4'd7;
  localparam logic [3:0]     ST_HITSTUN   = 4'd9;
  localparam logic [3:0]     ST_BLOCKSTUN = 4'd10;

  // Boxes are packed as {x1, x2, y1, y2}; index 0 is player 1, index 1 is player 2.
  logic        w_fight;
  logic [3:0]  w_state  [2];
  logic [39:0] w_basic  [2];
  logic [39:0] w_dir    [2];
  logic [39:0] w_hurt   [2];
  logic [1:0]  w_flag   [2];
  logic [2:0]  w_health [2];
  logic [2:0]  w_block  [2];
  logic        r_round_over;
  logic        r_prev_fight;
  logic [1:0]  r_winner;

  assign w_fight    = (gamestate == 3'd2);
  assign w_state[0] = p1_state;
  assign w_state[1] = p2_state;
  assign w_basic[0] = {p1_basic_x1, p1_basic_x2, p1_basic_y1, p1_basic_y2};
  assign w_basic[1] = {p2_basic_x1, p2_basic_x2, p2_basic_y1, p2_basic_y2};
  assign w_dir[0]   = {p1_dir_x1, p1_dir_x2, p1_dir_y1, p1_dir_y2};
  assign w_dir[1]   = {p2_dir_x1, p2_dir_x2, p2_dir_y1, p2_dir_y2};
  assign w_hurt[0]  = {p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2};
  assign w_hurt[1]  = {p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2};

  function automatic logic overlap(input logic [39:0] a, input logic [39:0] b);
    return (a[39:30] <= b[29:20]) && (b[39:30] <= a[29:20]) &&
           (a[19:10] <= b[9:0])   && (b[19:10] <= a[9:0]);
  endfunction

  // Each generate instance is one defender; its attacker is the other player.
  for (genvar gi = 0; gi < 2; gi++) begin : g_player
    localparam int AI = 1 - gi;
    logic [1:0]    r_flag;
    logic          r_blocked;
    logic          r_atk_done;
    logic [2:0]    r_health;
    logic [2:0]    r_block;
    logic [CW-1:0] r_regen_cnt;
    logic          w_att_active;
    logic          w_hittable;
    logic [1:0]    w_hit;
    logic [2:0]    w_dmg;

    assign w_att_active = (w_state[AI] == ST_BATK) || (w_state[AI] == ST_DATK);
    assign w_hittable   = w_fight && !r_round_over && !r_atk_done &&
                          (w_state[gi] != ST_HITSTUN) && (w_state[gi] != ST_BLOCKSTUN);
    assign w_dmg        = (r_flag == 2'b10) ? 3'd2 : 3'd1;

    always_comb begin
      w_hit = 2'b00;
      if (w_hittable) begin
        if ((w_state[AI] == ST_BATK) && overlap(w_basic[AI], w_hurt[gi]))
          w_hit = 2'b01;
        else if ((w_state[AI] == ST_DATK) && overlap(w_dir[AI], w_hurt[gi]))
          w_hit = 2'b10;
      end
    end

    always_ff @(posedge clk) begin
      if (rst || !w_fight) begin
        r_flag      <= 2'b00;
        r_blocked   <= 1'b0;
        r_atk_done  <= 1'b0;
        r_health    <= HEALTH_MAX;
        r_block     <= BLOCK_MAX;
        r_regen_cnt <= '0;
      end else begin
        r_flag    <= w_hit;
        r_blocked <= (w_state[gi] == ST_BACK) && (r_block != 3'd0);
        if (!w_att_active)
          r_atk_done <= 1'b0;
        else if (w_hit != 2'b00)
          r_atk_done <= 1'b1;
        // The pending hit lands one frame after its flag so the FSM sees pre-update block.
        if ((r_flag != 2'b00) && !r_blocked)
          r_health <= (r_health > w_dmg) ? r_health - w_dmg : 3'd0;
        if ((r_flag != 2'b00) && r_blocked) begin
          r_block     <= r_block - 3'd1;
          r_regen_cnt <= '0;
        end else if (r_block == BLOCK_MAX) begin
          r_regen_cnt <= '0;
        end else if (r_regen_cnt == REGEN_LAST) begin
          r_block     <= r_block + 3'd1;
          r_regen_cnt <= '0;
        end else begin
          r_regen_cnt <= r_regen_cnt + CW'(1);
        end
      end
    end

    assign w_flag[gi]   = r_flag;
    assign w_health[gi] = r_health;
    assign w_block[gi]  = r_block;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_round_over <= 1'b0;
      r_winner     <= 2'b00;
      r_prev_fight <= 1'b0;
    end else begin
      r_prev_fight <= w_fight;
      if (!w_fight) begin
        r_round_over <= 1'b0;
      end else if (!r_round_over && ((w_health[0] == 3'd0) || (w_health[1] == 3'd0))) begin
        r_round_over <= 1'b1;
        r_winner     <= {w_health[0] == 3'd0, w_health[1] == 3'd0};
      end else if (!r_prev_fight) begin
        r_winner <= 2'b00;
      end
    end
  end

  assign p1_hitFlag = w_flag[0];
  assign p2_hitFlag = w_flag[1];
  assign p1_health  = w_health[0];
  assign p2_health  = w_health[1];
  assign p1_block   = w_block[0];
  assign p2_block   = w_block[1];
  assign round_over = r_round_over;
  assign winner     = r_winner;

endmodule

// File: tb/tb_hit_resolver.sv
// Testbench for hit_resolver: directed scenarios plus randomized play checked
// against an event-queue reference model.
module tb_hit_resolver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] gamestate = 3'd2;
  logic [3:0] st [2];
  logic [9:0] bas  [2][4];
  logic [9:0] dr   [2][4];
  logic [9:0] hurt [2][4];
  logic [1:0] p1_flag, p2_flag, win;
  logic [2:0] p1_h, p2_h, p1_b, p2_b;
  logic       ro;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hit_resolver dut (
    .clk(clk), .rst(rst), .gamestate(gamestate),
    .p1_state(st[0]), .p2_state(st[1]),
    .p1_basic_x1(bas[0][0]), .p1_basic_x2(bas[0][1]), .p1_basic_y1(bas[0][2]), .p1_basic_y2(bas[0][3]),
    .p1_dir_x1(dr[0][0]), .p1_dir_x2(dr[0][1]), .p1_dir_y1(dr[0][2]), .p1_dir_y2(dr[0][3]),
    .p1_hurt_x1(hurt[0][0]), .p1_hurt_x2(hurt[0][1]), .p1_hurt_y1(hurt[0][2]), .p1_hurt_y2(hurt[0][3]),
    .p2_basic_x1(bas[1][0]), .p2_basic_x2(bas[1][1]), .p2_basic_y1(bas[1][2]), .p2_basic_y2(bas[1][3]),
    .p2_dir_x1(dr[1][0]), .p2_dir_x2(dr[1][1]), .p2_dir_y1(dr[1][2]), .p2_dir_y2(dr[1][3]),
    .p2_hurt_x1(hurt[1][0]), .p2_hurt_x2(hurt[1][1]), .p2_hurt_y1(hurt[1][2]), .p2_hurt_y2(hurt[1][3]),
    .p1_hitFlag(p1_flag), .p2_hitFlag(p2_flag),
    .p1_health(p1_h), .p2_health(p2_h),
    .p1_block(p1_b), .p2_block(p2_b),
    .round_over(ro), .winner(win)
  );

  // ---------------- reference model ----------------
  typedef struct { int due; int d; bit blk; int kind; } upd_t;
  upd_t       pend [$];
  upd_t       upd;
  int         cyc = 0;
  logic [2:0] m_health [2];
  logic [2:0] m_block  [2];
  logic [1:0] m_flag   [2];
  int         m_anchor [2];
  bit         m_done   [2];
  bit         m_ro = 1'b0, m_prev_fight = 1'b0;
  logic [1:0] m_winner = 2'b00;
  logic [2:0] h0 [2];
  logic [2:0] b0 [2];
  bit         dec [2];
  logic [1:0] nf [2];

  // Intersection of two closed intervals in each axis is non-empty.
  function automatic bit ovl(input logic [9:0] ax1, ax2, ay1, ay2, bx1, bx2, by1, by2);
    int lx, hx, ly, hy;
    lx = (ax1 > bx1) ? ax1 : bx1;
    hx = (ax2 < bx2) ? ax2 : bx2;
    ly = (ay1 > by1) ? ay1 : by1;
    hy = (ay2 < by2) ? ay2 : by2;
    return (lx <= hx) && (ly <= hy);
  endfunction

  initial begin
    for (int p = 0; p < 2; p++) begin
      m_health[p] = 3'd5; m_block[p] = 3'd3; m_flag[p] = 2'b00; m_anchor[p] = 0; m_done[p] = 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst || gamestate != 3'd2) begin
      for (int p = 0; p < 2; p++) begin
        m_health[p] = 3'd5; m_block[p] = 3'd3; m_flag[p] = 2'b00; m_done[p] = 1'b0; m_anchor[p] = cyc;
      end
      pend.delete();
      m_ro = 1'b0;
      m_prev_fight = 1'b0;
      if (rst) m_winner = 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        h0[p] = m_health[p]; b0[p] = m_block[p]; dec[p] = 1'b0; nf[p] = 2'b00;
      end
      if (!m_prev_fight) m_winner = 2'b00;
      while (pend.size() > 0 && pend[0].due == cyc) begin
        upd = pend.pop_front();
        if (upd.blk) begin
          m_block[upd.d] = m_block[upd.d] - 3'd1;
          dec[upd.d] = 1'b1;
          m_anchor[upd.d] = cyc;
        end else begin
          int dmg;
          dmg = (upd.kind == 2) ? 2 : 1;
          m_health[upd.d] = (int'(m_health[upd.d]) > dmg) ? 3'(int'(m_health[upd.d]) - dmg) : 3'd0;
        end
      end
      for (int d = 0; d < 2; d++) begin
        int a, kind;
        a = 1 - d;
        kind = 0;
        if (st[a] == 4'd4 && ovl(bas[a][0], bas[a][1], bas[a][2], bas[a][3],
                                 hurt[d][0], hurt[d][1], hurt[d][2], hurt[d][3])) kind = 1;
        if (st[a] == 4'd7 && ovl(dr[a][0], dr[a][1], dr[a][2], dr[a][3],
                                 hurt[d][0], hurt[d][1], hurt[d][2], hurt[d][3])) kind = 2;
        if (kind != 0 && !m_ro && !m_done[a] && st[d] != 4'd9 && st[d] != 4'd10) begin
          nf[d] = 2'(kind);
          pend.push_back('{cyc + 1, d, (st[d] == 4'd2) && (b0[d] > 0), kind});
        end
      end
      for (int a = 0; a < 2; a++) begin
        if (st[a] != 4'd4 && st[a] != 4'd7) m_done[a] = 1'b0;
        else if (nf[1-a] != 2'b00) m_done[a] = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        if (!dec[p]) begin
          if (b0[p] == 3'd3) m_anchor[p] = cyc;
          else if (cyc - m_anchor[p] == 120) begin
            m_block[p] = m_block[p] + 3'd1;
            m_anchor[p] = cyc;
          end
        end
      end
      if (!m_ro && (h0[0] == 0 || h0[1] == 0)) begin
        m_ro = 1'b1;
        m_winner = {h0[0] == 3'd0, h0[1] == 3'd0};
      end
      m_flag[0] = nf[0];
      m_flag[1] = nf[1];
      m_prev_fight = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_box(input int p, input int kind, input int x1, x2, y1, y2);
    case (kind)
      0: begin bas[p][0] = 10'(x1); bas[p][1] = 10'(x2); bas[p][2] = 10'(y1); bas[p][3] = 10'(y2); end
      1: begin dr[p][0] = 10'(x1); dr[p][1] = 10'(x2); dr[p][2] = 10'(y1); dr[p][3] = 10'(y2); end
      default: begin hurt[p][0] = 10'(x1); hurt[p][1] = 10'(x2); hurt[p][2] = 10'(y1); hurt[p][3] = 10'(y2); end
    endcase
  endtask

  // Every attack box overlaps the opponent's hurtbox; states idle.
  task automatic layout_default();
    set_box(0, 2, 100, 150, 100, 150);
    set_box(1, 2, 200, 250, 100, 150);
    set_box(0, 0, 160, 210, 100, 150);
    set_box(0, 1, 160, 210, 100, 150);
    set_box(1, 0, 140, 190, 100, 150);
    set_box(1, 1, 140, 190, 100, 150);
    st[0] = 4'd0; st[1] = 4'd0;
  endtask

  task automatic fresh_fight();
    layout_default();
    gamestate = 3'd0; tick(1);
    gamestate = 3'd2; tick(1);
  endtask

  task automatic rand_box(output logic [9:0] x1, x2, y1, y2);
    int base;
    base = ($urandom_range(0, 9) == 0) ? 960 : 0;
    x1 = 10'(base + $urandom_range(0, 40)); x2 = x1 + 10'($urandom_range(0, 23));
    y1 = 10'(base + $urandom_range(0, 40)); y2 = y1 + 10'($urandom_range(0, 23));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; gamestate = 3'd2; layout_default();
    tick(2);
    rst = 1'b0;
    tick(1);
    n_checks++; if (p1_flag !== 2'b00 || p2_flag !== 2'b00) begin n_errors++; $display("FAIL reset_flags: got %b/%b expected 00/00", p1_flag, p2_flag); end
    n_checks++; if (p1_h !== 3'd5 || p2_h !== 3'd5) begin n_errors++; $display("FAIL reset_health: got %0d/%0d expected 5/5", p1_h, p2_h); end
    n_checks++; if (p1_b !== 3'd3 || p2_b !== 3'd3) begin n_errors++; $display("FAIL reset_block: got %0d/%0d expected 3/3", p1_b, p2_b); end
    n_checks++; if (ro !== 1'b0 || win !== 2'b00) begin n_errors++; $display("FAIL reset_round: got ro=%b win=%b expected 0/00", ro, win); end
  endtask

  task automatic test_basic_hit();
    st[0] = 4'd4; tick(1);
    n_checks++; if (p2_flag !== 2'b01) begin n_errors++; $display("FAIL basic_flag: got %b expected 01", p2_flag); end
    n_checks++; if (p1_flag !== 2'b00) begin n_errors++; $display("FAIL basic_attacker_flag: got %b expected 00", p1_flag); end
    n_checks++; if (p2_h !== 3'd5) begin n_errors++; $display("FAIL basic_health_pre: got %0d expected 5", p2_h); end
    tick(1);
    n_checks++; if (p2_flag !== 2'b00) begin n_errors++; $display("FAIL basic_flag_pulse: got %b expected 00", p2_flag); end
    n_checks++; if (p2_h !== 3'd4) begin n_errors++; $display("FAIL basic_health_post: got %0d expected 4", p2_h); end
    tick(1);
    n_checks++; if (p2_flag !== 2'b00 || p2_h !== 3'd4) begin n_errors++; $display("FAIL basic_one_hit: got flag=%b h=%0d expected 00/4", p2_flag, p2_h); end
    st[0] = 4'd0; tick(1);
  endtask

  task automatic test_edges();
    set_box(0, 0, 100, 150, 100, 150);
    set_box(1, 2, 151, 200, 100, 150);
    st[0] = 4'd4;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      n_checks++; if (p2_flag !== 2'b00) begin n_errors++; $display("FAIL edge_gap_x cyc%0d: got %b expected 00", i, p2_flag); end
    end
    st[0] = 4'd0; tick(1);
    set_box(1, 2, 120, 130, 150, 200);
    st[0] = 4'd4; tick(1);
    n_checks++; if (p2_flag !== 2'b01) begin n_errors++; $display("FAIL edge_touch_y: got %b expected 01", p2_flag); end
    st[0] = 4'd0; tick(1);
    n_checks++; if (p2_h !== 3'd3) begin n_errors++; $display("FAIL edge_touch_y_health: got %0d expected 3", p2_h); end
    set_box(1, 2, 150, 200, 100, 150);
    st[0] = 4'd4; tick(1);
    n_checks++; if (p2_flag !== 2'b01) begin n_errors++; $display("FAIL edge_touch_x: got %b expected 01", p2_flag); end
    st[0] = 4'd0; tick(1);
    n_checks++; if (p2_h !== 3'd2) begin n_errors++; $display("FAIL edge_touch_x_health: got %0d expected 2", p2_h); end
    st[1] = 4'd9; st[0] = 4'd4; tick(1);
    n_checks++; if (p2_flag !== 2'b00) begin n_errors++; $display("FAIL hitstun_immune: got %b expected 00", p2_flag); end
    st[1] = 4'd10; tick(1);
    n_checks++; if (p2_flag !== 2'b00) begin n_errors++; $display("FAIL blockstun_immune: got %b expected 00", p2_flag); end
    st[0] = 4'd0; st[1] = 4'd0; tick(1);
    n_checks++; if (p2_h !== 3'd2) begin n_errors++; $display("FAIL stun_health: got %0d expected 2", p2_h); end
    gamestate = 3'd0; tick(1);
    n_checks++; if (p2_h !== 3'd5 || p2_b !== 3'd3) begin n_errors++; $display("FAIL nonfight_restore: got h=%0d b=%0d expected 5/3", p2_h, p2_b); end
  endtask

  task automatic test_block();
    fresh_fight();
    st[1] = 4'd2;
    for (int i = 0; i < 3; i++) begin
      st[0] = 4'd7; tick(1);
      n_checks++; if (p2_flag !== 2'b10 || p2_b !== 3'(3 - i)) begin n_errors++; $display("FAIL block_flag #%0d: got flag=%b b=%0d expected 10/%0d", i, p2_flag, p2_b, 3 - i); end
      st[0] = 4'd0; tick(1);
      n_checks++; if (p2_h !== 3'd5 || p2_b !== 3'(2 - i)) begin n_errors++; $display("FAIL block_update #%0d: got h=%0d b=%0d expected 5/%0d", i, p2_h, p2_b, 2 - i); end
    end
    st[0] = 4'd7; tick(1);
    n_checks++; if (p2_flag !== 2'b10) begin n_errors++; $display("FAIL block_empty_flag: got %b expected 10", p2_flag); end
    st[0] = 4'd0; tick(1);
    n_checks++; if (p2_h !== 3'd3 || p2_b !== 3'd0) begin n_errors++; $display("FAIL block_empty_dmg: got h=%0d b=%0d expected 3/0", p2_h, p2_b); end
    st[1] = 4'd0;
  endtask

  task automatic test_regen();
    fresh_fight();
    st[1] = 4'd2; st[0] = 4'd7; tick(1);
    st[0] = 4'd0; st[1] = 4'd0; tick(1);
    n_checks++; if (p2_b !== 3'd2) begin n_errors++; $display("FAIL regen_start: got %0d expected 2", p2_b); end
    tick(119);
    n_checks++; if (p2_b !== 3'd2) begin n_errors++; $display("FAIL regen_early: got %0d expected 2", p2_b); end
    tick(1);
    n_checks++; if (p2_b !== 3'd3) begin n_errors++; $display("FAIL regen_gain: got %0d expected 3", p2_b); end
    tick(50);
    n_checks++; if (p2_b !== 3'd3 || p1_b !== 3'd3) begin n_errors++; $display("FAIL regen_cap: got %0d/%0d expected 3/3", p1_b, p2_b); end
  endtask

  task automatic test_trade();
    int kinds [3];
    int hexp [3];
    kinds[0] = 7; kinds[1] = 4; kinds[2] = 7;
    hexp[0] = 3; hexp[1] = 2; hexp[2] = 0;
    fresh_fight();
    for (int i = 0; i < 3; i++) begin
      logic [1:0] fexp;
      fexp = (kinds[i] == 7) ? 2'b10 : 2'b01;
      st[0] = 4'(kinds[i]); st[1] = 4'(kinds[i]); tick(1);
      n_checks++; if (p1_flag !== fexp || p2_flag !== fexp) begin n_errors++; $display("FAIL trade_flags #%0d: got %b/%b expected %b/%b", i, p1_flag, p2_flag, fexp, fexp); end
      st[0] = 4'd0; st[1] = 4'd0; tick(1);
      n_checks++; if (p1_h !== 3'(hexp[i]) || p2_h !== 3'(hexp[i])) begin n_errors++; $display("FAIL trade_health #%0d: got %0d/%0d expected %0d", i, p1_h, p2_h, hexp[i]); end
    end
    n_checks++; if (ro !== 1'b0) begin n_errors++; $display("FAIL trade_ro_early: got %b expected 0", ro); end
    tick(1);
    n_checks++; if (ro !== 1'b1 || win !== 2'b11) begin n_errors++; $display("FAIL trade_draw: got ro=%b win=%b expected 1/11", ro, win); end
    gamestate = 3'd0; tick(1);
    n_checks++; if (p1_h !== 3'd5 || p2_h !== 3'd5 || win !== 2'b11 || ro !== 1'b0) begin n_errors++; $display("FAIL trade_nonfight: got h=%0d/%0d win=%b ro=%b expected 5/5 11 0", p1_h, p2_h, win, ro); end
    gamestate = 3'd2; tick(1);
    n_checks++; if (win !== 2'b00) begin n_errors++; $display("FAIL trade_winner_clear: got %b expected 00", win); end
  endtask

  task automatic test_winner_single();
    fresh_fight();
    for (int i = 0; i < 3; i++) begin
      st[0] = 4'd7; tick(1);
      st[0] = 4'd0; tick(1);
    end
    n_checks++; if (p2_h !== 3'd0 || p1_h !== 3'd5) begin n_errors++; $display("FAIL ko_health: got %0d/%0d expected 5/0", p1_h, p2_h); end
    tick(1);
    n_checks++; if (ro !== 1'b1 || win !== 2'b01) begin n_errors++; $display("FAIL ko_p1_wins: got ro=%b win=%b expected 1/01", ro, win); end
    st[1] = 4'd7; tick(1);
    n_checks++; if (p1_flag !== 2'b00) begin n_errors++; $display("FAIL ko_no_hits: got %b expected 00", p1_flag); end
    st[1] = 4'd0; gamestate = 3'd0; tick(1);
    n_checks++; if (ro !== 1'b0 || win !== 2'b01) begin n_errors++; $display("FAIL ko_hold: got ro=%b win=%b expected 0/01", ro, win); end
    gamestate = 3'd2; tick(1);
  endtask

  task automatic test_gamestate_abort();
    fresh_fight();
    st[0] = 4'd4; tick(1);
    n_checks++; if (p2_flag !== 2'b01) begin n_errors++; $display("FAIL abort_setup: got %b expected 01", p2_flag); end
    gamestate = 3'd0; st[0] = 4'd0; tick(1);
    gamestate = 3'd2; tick(1);
    n_checks++; if (p2_flag !== 2'b00 || p2_h !== 3'd5) begin n_errors++; $display("FAIL abort_discard: got flag=%b h=%0d expected 00/5", p2_flag, p2_h); end
  endtask

  task automatic test_reset_mid();
    fresh_fight();
    st[0] = 4'd4; tick(1);
    n_checks++; if (p2_flag !== 2'b01) begin n_errors++; $display("FAIL rstmid_setup: got %b expected 01", p2_flag); end
    rst = 1'b1; st[0] = 4'd0; tick(1);
    n_checks++; if (p1_flag !== 2'b00 || p2_flag !== 2'b00 || p1_h !== 3'd5 || p2_h !== 3'd5 ||
                    p1_b !== 3'd3 || p2_b !== 3'd3 || ro !== 1'b0 || win !== 2'b00) begin
      n_errors++; $display("FAIL rstmid_values: got f=%b/%b h=%0d/%0d b=%0d/%0d ro=%b win=%b expected reset values",
                           p1_flag, p2_flag, p1_h, p2_h, p1_b, p2_b, ro, win); end
    rst = 1'b0; tick(1);
    n_checks++; if (p2_flag !== 2'b00 || p2_h !== 3'd5) begin n_errors++; $display("FAIL rstmid_after: got flag=%b h=%0d expected 00/5", p2_flag, p2_h); end
    st[0] = 4'd4; rst = 1'b1; tick(1);
    st[0] = 4'd0; rst = 1'b0; tick(1);
    n_checks++; if (p2_flag !== 2'b00 || p2_h !== 3'd5) begin n_errors++; $display("FAIL rst_at_detect: got flag=%b h=%0d expected 00/5", p2_flag, p2_h); end
  endtask

  task automatic test_random();
    int states [8];
    states[0] = 0; states[1] = 2; states[2] = 4; states[3] = 7;
    states[4] = 9; states[5] = 10; states[6] = 4; states[7] = 7;
    rst = 1'b1; gamestate = 3'd2; layout_default(); tick(1);
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      tick(1);
      n_checks++; if (p1_flag !== m_flag[0]) begin n_errors++; $display("FAIL rnd_p1_flag c=%0d: got %b expected %b", c, p1_flag, m_flag[0]); end
      n_checks++; if (p2_flag !== m_flag[1]) begin n_errors++; $display("FAIL rnd_p2_flag c=%0d: got %b expected %b", c, p2_flag, m_flag[1]); end
      n_checks++; if (p1_h !== m_health[0]) begin n_errors++; $display("FAIL rnd_p1_health c=%0d: got %0d expected %0d", c, p1_h, m_health[0]); end
      n_checks++; if (p2_h !== m_health[1]) begin n_errors++; $display("FAIL rnd_p2_health c=%0d: got %0d expected %0d", c, p2_h, m_health[1]); end
      n_checks++; if (p1_b !== m_block[0]) begin n_errors++; $display("FAIL rnd_p1_block c=%0d: got %0d expected %0d", c, p1_b, m_block[0]); end
      n_checks++; if (p2_b !== m_block[1]) begin n_errors++; $display("FAIL rnd_p2_block c=%0d: got %0d expected %0d", c, p2_b, m_block[1]); end
      n_checks++; if (ro !== m_ro) begin n_errors++; $display("FAIL rnd_round_over c=%0d: got %b expected %b", c, ro, m_ro); end
      n_checks++; if (win !== m_winner) begin n_errors++; $display("FAIL rnd_winner c=%0d: got %b expected %b", c, win, m_winner); end
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 2) gamestate = 3'($urandom_range(0, 7));
      else if (gamestate != 3'd2 && $urandom_range(0, 3) == 0) gamestate = 3'd2;
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 99) < 25) st[p] = 4'(states[$urandom_range(0, 7)]);
        if ($urandom_range(0, 99) < 10) begin
          rand_box(bas[p][0], bas[p][1], bas[p][2], bas[p][3]);
          rand_box(dr[p][0], dr[p][1], dr[p][2], dr[p][3]);
          rand_box(hurt[p][0], hurt[p][1], hurt[p][2], hurt[p][3]);
        end
      end
    end
  endtask

  initial begin
    layout_default();
    test_reset();
    test_basic_hit();
    test_edges();
    test_block();
    test_regen();
    test_trade();
    test_winner_single();
    test_gamestate_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
